// File: rtl/cla32_addsub_pipe.sv
// cla32_addsub_pipe: two-stage pipelined 32-bit carry-lookahead adder/subtractor.
// Stage 1 forms bit and 4-bit group generate/propagate; stage 2 resolves all carries and flags.
module cla32_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  if (WIDTH != 32) begin : g_width_chk
    $error("cla32_addsub_pipe: only WIDTH=32 is supported");
  end

  // Bit generates are kept only for the low three bits of each group; bit 3 is
  // folded into the group (G,P) pair and its carry-out comes from the next level.
  typedef struct packed {
    logic [31:0]     p;
    logic [7:0][2:0] gl;
    logic [7:0]      gg;
    logic [7:0]      gp;
    logic            cin;
  } s1_t;

  logic s1_valid, s2_valid, s1_adv, s2_adv;
  s1_t  s1, s1_d;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // ---------------- stage 1: bit and group generate/propagate
  logic [31:0]     bx, g1, p1;
  logic [7:0]      gg1, gp1;
  logic [7:0][2:0] gl1;

  assign bx = b ^ {32{sub}};
  assign g1 = a & bx;
  assign p1 = a ^ bx;

  for (genvar i = 0; i < 8; i++) begin : g_grp1
    cla_gp4 u_gp (.g(g1[4*i +: 4]), .p(p1[4*i +: 4]), .gg(gg1[i]), .gp(gp1[i]));
    assign gl1[i] = g1[4*i +: 3];
  end

  assign s1_d = '{p: p1, gl: gl1, gg: gg1, gp: gp1, cin: sub};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= s1_d;
    end
  end

  // ---------------- stage 2: block lookahead, group carry-ins, bit carries
  logic       bg_lo, bp_lo, bg_hi, bp_hi;
  logic [2:1] cb;  // cb[1] = carry into bit 16, cb[2] = carry out of bit 31
  logic [7:0] cg;
  logic [31:0] cbit, sum_d;

  cla_gp4 u_blo (.g(s1.gg[3:0]), .p(s1.gp[3:0]), .gg(bg_lo), .gp(bp_lo));
  cla_gp4 u_bhi (.g(s1.gg[7:4]), .p(s1.gp[7:4]), .gg(bg_hi), .gp(bp_hi));
  cla_c2  u_top (.g({bg_hi, bg_lo}), .p({bp_hi, bp_lo}), .ci(s1.cin), .c(cb));

  assign cg[0] = s1.cin;
  assign cg[4] = cb[1];
  cla_c3 u_clo (.g(s1.gg[2:0]), .p(s1.gp[2:0]), .ci(s1.cin), .c(cg[3:1]));
  cla_c3 u_chi (.g(s1.gg[6:4]), .p(s1.gp[6:4]), .ci(cb[1]),  .c(cg[7:5]));

  for (genvar i = 0; i < 8; i++) begin : g_grp2
    assign cbit[4*i] = cg[i];
    cla_c3 u_cb (.g(s1.gl[i]), .p(s1.p[4*i +: 3]), .ci(cg[i]), .c(cbit[4*i+1 +: 3]));
  end

  assign sum_d = s1.p ^ cbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= cb[2];
        ovf  <= cbit[31] ^ cb[2];
        zero <= ~|sum_d;
      end
    end
  end
endmodule

// 4-bit group generate/propagate cell.
module cla_gp4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  output logic       gg,
  output logic       gp
);
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
endmodule

// 3-bit lookahead carry cell: carries into positions 1..3 from position 0 carry-in.
module cla_c3 (
  input  logic [2:0] g,
  input  logic [2:0] p,
  input  logic       ci,
  output logic [3:1] c
);
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
endmodule

// 2-bit lookahead carry cell.
module cla_c2 (
  input  logic [1:0] g,
  input  logic [1:0] p,
  input  logic       ci,
  output logic [2:1] c
);
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
endmodule

// File: tb/tb_cla32_addsub_pipe.sv
// Self-checking bench for cla32_addsub_pipe: directed spec vectors, streaming,
// backpressure, mid-flight reset and a randomized run against a 33-bit arithmetic model.
module tb_cla32_addsub_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;
  int          errors = 0, checks = 0;

  cla32_addsub_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Expected {sum, cout, ovf, zero} from plain arithmetic and sign rules.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [32:0] r;
    logic        v;
    r = {1'b0, x} + {1'b0, (s ? ~y : y)} + {32'd0, s};
    if (s) v = (x[31] != y[31]) && (r[31] != x[31]);
    else   v = (x[31] == y[31]) && (r[31] != x[31]);
    return {r[31:0], r[32], v, (r[31:0] == 32'd0)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {out_valid, sum, cout, ovf, zero});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'h0000_0001, 32'h8000_0000, 32'd5, 32'h7FFF_FFFF};
    logic [31:0] tb [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'd7, 32'h0000_0001};
    logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [34:0] te [4] = '{{32'h0000_0000, 1'b1, 1'b0, 1'b1},
                            {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
                            {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
                            {32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; sub = ts[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_early_valid got=%b want=0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_latency got=%b want=1", i, out_valid);
      end
      checks++;
      if ({sum, cout, ovf, zero} !== te[i]) begin
        errors++;
        $display("FAIL directed%0d_result got=%h want=%h", i, {sum, cout, ovf, zero}, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = (k < 4); a = 32'(k + 1); b = 32'(k + 1); sub = 1'b0;
      #1;
      checks++;
      if (k >= 2 && k < 6) begin
        if (out_valid !== 1'b1 || sum !== 32'(2 * (k - 1))) begin
          errors++;
          $display("FAIL b2b_cycle%0d got valid=%b sum=%0d want valid=1 sum=%0d",
                   k, out_valid, sum, 2 * (k - 1));
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_cycle%0d got valid=%b want 0", k, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [34:0] q[$];
    int          issued = 0, got = 0;
    logic        held = 1'b0;
    logic [35:0] prev = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = (issued < 6);
      a = 32'(100 + issued * 3); b = 32'(issued); sub = issued[0];
      #1;
      if (held) begin
        checks++;
        if ({out_valid, sum, cout, ovf, zero} !== prev) begin
          errors++;
          $display("FAIL bp_stall_hold got=%h want=%h", {out_valid, sum, cout, ovf, zero}, prev);
        end
      end
      if (k >= 3 && k <= 5) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready_full cycle%0d got=%b want=0", k, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || {sum, cout, ovf, zero} !== q[0]) begin
          errors++;
          $display("FAIL bp_result got=%h want=%h", {sum, cout, ovf, zero},
                   (q.size() != 0) ? q[0] : 35'd0);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sub));
        issued++;
      end
      held = out_valid && !out_ready;
      prev = {out_valid, sum, cout, ovf, zero};
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got=%0d pending=%0d want 6 and 0", got, q.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd11; b = 32'd22; sub = 1'b0;
    @(negedge clk);
    a = 32'd33; b = 32'd44;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_full got valid=%b ready=%b want 1 0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_async got valid=%b sum=%h want 0 0", out_valid, sum);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stale got valid=%b want 0", out_valid);
    end
    a = 32'd9; b = 32'd3; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_early got valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {sum, cout, ovf, zero} !== {32'd6, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_newop got valid=%b res=%h want 1 %h", out_valid,
               {sum, cout, ovf, zero}, {32'd6, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic        held = 1'b0;
    logic [35:0] prev = '0;
    for (int k = 0; k < 10004; k++) begin
      @(negedge clk);
      if (k < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: b = a;
          1: b = ~a;
          2: a = 32'h8000_0000;
          default: ;
        endcase
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (held) begin
        checks++;
        if ({out_valid, sum, cout, ovf, zero} !== prev) begin
          errors++;
          $display("FAIL rnd_stall_hold cycle%0d got=%h want=%h", k,
                   {out_valid, sum, cout, ovf, zero}, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || {sum, cout, ovf, zero} !== q[0]) begin
          errors++;
          $display("FAIL rnd_result cycle%0d got=%h want=%h", k, {sum, cout, ovf, zero},
                   (q.size() != 0) ? q[0] : 35'd0);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(a, b, sub));
      held = out_valid && !out_ready;
      prev = {out_valid, sum, cout, ovf, zero};
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla32_addsub_pipe.md
Name: cla32_addsub_pipe

Overview:
- 32-bit two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides.
- It is built from the group carry-lookahead cells (4-bit, 3-bit and 2-bit generate/propagate/carry cells) and is the datapath that consumes their generate, propagate and carry outputs.
- It feeds the square-root iteration controller, which needs signed remainder updates (R ± T) with sign, carry and overflow flags.

Parameters:
- WIDTH, 32: operand width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand transfer request.
- in_ready, output, 1: block can accept operands this cycle.
- a, input, 32: operand A.
- b, input, 32: operand B.
- sub, input, 1: 0 selects A+B; 1 selects A−B, computed as A + ~B + 1.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts result.
- sum, output, 32: result bits [31:0].
- cout, output, 1: carry out of bit 31. For subtract, 1 means no borrow (A ≥ B unsigned).
- ovf, output, 1: signed overflow, carry into bit 31 XOR carry out of bit 31.
- zero, output, 1: sum == 0.

Behaviour:
- Reset (async assert, sync-release domain is upstream's responsibility):
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - sum = 0, cout = 0, ovf = 0, zero = 0.
  - Takes effect immediately on rst_n low, mid-operation included. All in-flight operations are discarded, never emitted.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (register S1):
  - On input transfer, computes per-bit g = a & b' and p = a ^ b', where b' = b ^ {32{sub}} and cin = sub.
  - Reduces to 8 group (g,p) pairs with 4-bit lookahead.
  - Registers: p[31:0], the 8 group (G,P) pairs, cin, s1_valid.
- Stage 2 (register S2 = output register):
  - Second lookahead level: two 4-group cells plus one 2-cell combining their group outputs. Produces the 8 group carry-ins.
  - Each group's 4-bit lookahead then produces bit carries c[31:0] and c[32].
  - sum = p ^ c[31:0]; cout = c[32]; ovf = c[31] ^ c[32]; zero = ~|sum.
  - No ripple path longer than one group is permitted.
- Latency: exactly 2 cycles from input transfer to out_valid = 1 when out_ready is held high. Throughput is 1 operation per cycle.
- Flow control:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - S2 loads from S1 when s2_adv. s2_valid_next = s1_valid, or holds when ~s2_adv.
  - S1 loads on s1_adv. s1_valid_next = in_valid & in_ready, or holds when ~s1_adv.
- Stall: with out_ready low, sum/cout/ovf/zero/out_valid hold bit-stable. At most 2 operations are buffered; in_ready drops when both stages are full.
- Simultaneous events: input and output transfer in the same cycle with both stages full is legal. The pipeline shifts, nothing is lost or duplicated, and order is preserved.
- Bubbles: when out_valid = 0, output data content is don't-care for the checker, but it must not change while out_valid = 1 and out_ready = 0.
- X-safety: a and b are not sampled when no input transfer occurs; the registers hold their value.

Test Plan:
1. Add wrap: a=0x0000_0001, b=0xFFFF_FFFF, sub=0, out_ready=1 -> out_valid exactly 2 cycles after transfer; sum=0x0000_0000, cout=1, ovf=0, zero=1.
2. Subtract overflow: a=0x8000_0000, b=0x0000_0001, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1, zero=0.
3. Borrow and full carry chain:
   - a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
   - a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, cout=0, ovf=1.
4. Streaming and backpressure:
   - Issue 4 back-to-back ops (1+1, 2+2, 3+3, 4+4) with out_ready=1 -> results 2, 4, 6, 8 on 4 consecutive cycles.
   - Drop out_ready for 3 cycles mid-stream -> in_ready=0 once 2 ops are buffered, outputs held stable, no loss, no duplication, order preserved after release.
5. Reset mid-operation: assert rst_n=0 with both stages valid -> out_valid=0 and sum=0 immediately (same cycle, asynchronous); after release, no stale result appears, and the first new op returns after 2 cycles.
6. Random regression: 10k random a/b/sub with random in_valid and out_ready -> every result matches a golden 33-bit model for sum/cout/ovf/zero, in issue order.
